// File: rtl/clk_gen_ctrl_pkg.sv
// Shared definitions for the programmable clock-pulse generator.
// Holds the sequencer state encoding used by clk_gen_ctrl.
package clk_gen_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    // Sequencer states: idle, HIGH phase, LOW phase of the generated clock.
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/clk_gen_phase_cnt.sv
// Loadable down-counter with a zero flag; times one HIGH or LOW phase.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       load load_val (takes priority over dec)
//   load_val   value to load
//   dec        decrement by one (saturates at zero)
//   zero_c     counter currently at zero (combinational from the register)
module clk_gen_phase_cnt #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 dec,
    output logic                 zero_c
);

    logic [CNT_WIDTH-1:0] cnt_q;

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/clk_gen_ctrl.sv
// Programmable clock-pulse generator / sequencer.
// Produces a registered clock CLK_OUT with programmable HIGH/LOW phase
// lengths, START/STOP handshakes and an optional burst period count.
// Ports:
//   CLK, RESET          system clock, asynchronous active-high reset
//   CFG_WR              write CFG_HIGH/CFG_LOW into the shadow registers
//   CFG_HIGH, CFG_LOW   phase lengths in CLK cycles (0 behaves as 1)
//   START, STOP         single-cycle start / stop-after-period requests
//   BURST_LEN           periods to generate, 0 = continuous (sampled on START)
//   CLK_OUT             generated clock
//   RISE, FALL          first HIGH / first LOW cycle of each period
//   BUSY                generator not idle
//   DONE                one-cycle pulse on return to idle
module clk_gen_ctrl
    import clk_gen_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH    = 8,
    parameter int unsigned BURST_WIDTH  = 16,
    parameter int unsigned DEFAULT_HIGH = 10,
    parameter int unsigned DEFAULT_LOW  = 10
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   CFG_WR,
    input  logic [CNT_WIDTH-1:0]   CFG_HIGH,
    input  logic [CNT_WIDTH-1:0]   CFG_LOW,
    input  logic                   START,
    input  logic                   STOP,
    input  logic [BURST_WIDTH-1:0] BURST_LEN,
    output logic                   CLK_OUT,
    output logic                   RISE,
    output logic                   FALL,
    output logic                   BUSY,
    output logic                   DONE
);

    // A programmed length of zero still yields a one-cycle phase.
    function automatic logic [CNT_WIDTH-1:0] clamp1(input logic [CNT_WIDTH-1:0] v);
        return (v == '0) ? CNT_WIDTH'(1) : v;
    endfunction

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   shadow_high_q, shadow_high_d;
    logic [CNT_WIDTH-1:0]   shadow_low_q, shadow_low_d;
    logic [CNT_WIDTH-1:0]   act_low_q, act_low_d;
    logic [BURST_WIDTH-1:0] burst_q, burst_d;
    logic                   burst_en_q, burst_en_d;
    logic                   stop_pend_q, stop_pend_d;
    logic                   clk_out_d, rise_d, fall_d, busy_d, done_d;

    logic [CNT_WIDTH-1:0]   eff_high_c, eff_low_c;
    logic                   last_c;
    logic                   ph_load, ph_dec, ph_zero_c;
    logic [CNT_WIDTH-1:0]   ph_val;

    // Phase-length timer shared by the HIGH and LOW phases
    clk_gen_phase_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_phase_cnt (
        .clk      (CLK),
        .rst      (RESET),
        .load     (ph_load),
        .load_val (ph_val),
        .dec      (ph_dec),
        .zero_c   (ph_zero_c)
    );

    // State, configuration and output registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= IDLE;
            shadow_high_q <= CNT_WIDTH'(DEFAULT_HIGH);
            shadow_low_q  <= CNT_WIDTH'(DEFAULT_LOW);
            act_low_q     <= CNT_WIDTH'(DEFAULT_LOW);
            burst_q       <= '0;
            burst_en_q    <= 1'b0;
            stop_pend_q   <= 1'b0;
            CLK_OUT       <= 1'b0;
            RISE          <= 1'b0;
            FALL          <= 1'b0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_high_q <= shadow_high_d;
            shadow_low_q  <= shadow_low_d;
            act_low_q     <= act_low_d;
            burst_q       <= burst_d;
            burst_en_q    <= burst_en_d;
            stop_pend_q   <= stop_pend_d;
            CLK_OUT       <= clk_out_d;
            RISE          <= rise_d;
            FALL          <= fall_d;
            BUSY          <= busy_d;
            DONE          <= done_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        shadow_high_d = CFG_WR ? CFG_HIGH : shadow_high_q;
        shadow_low_d  = CFG_WR ? CFG_LOW  : shadow_low_q;
        act_low_d     = act_low_q;
        burst_d       = burst_q;
        burst_en_d    = burst_en_q;
        stop_pend_d   = stop_pend_q;
        ph_load       = 1'b0;
        ph_dec        = 1'b0;
        ph_val        = '0;
        rise_d        = 1'b0;
        fall_d        = 1'b0;
        done_d        = 1'b0;
        last_c        = 1'b0;
        // A config write coinciding with a period start is used immediately.
        eff_high_c    = clamp1(shadow_high_d);
        eff_low_c     = clamp1(shadow_low_d);

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d     = HIGH;
                    burst_d     = BURST_LEN;
                    burst_en_d  = (BURST_LEN != '0);
                    stop_pend_d = STOP;
                    act_low_d   = eff_low_c;
                    ph_load     = 1'b1;
                    ph_val      = eff_high_c - CNT_WIDTH'(1);
                    rise_d      = 1'b1;
                end
            end
            HIGH: begin
                if (STOP) begin
                    stop_pend_d = 1'b1;
                end
                if (ph_zero_c) begin
                    state_d = LOW;
                    ph_load = 1'b1;
                    ph_val  = act_low_q - CNT_WIDTH'(1);
                    fall_d  = 1'b1;
                end else begin
                    ph_dec = 1'b1;
                end
            end
            LOW: begin
                if (STOP) begin
                    stop_pend_d = 1'b1;
                end
                if (ph_zero_c) begin
                    // End of period: count it, then stop or start the next one.
                    last_c = burst_en_q && (burst_q == BURST_WIDTH'(1));
                    if (burst_en_q) begin
                        burst_d = burst_q - BURST_WIDTH'(1);
                    end
                    if (stop_pend_q || STOP || last_c) begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        state_d   = HIGH;
                        act_low_d = eff_low_c;
                        ph_load   = 1'b1;
                        ph_val    = eff_high_c - CNT_WIDTH'(1);
                        rise_d    = 1'b1;
                    end
                end else begin
                    ph_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        clk_out_d = (state_d == HIGH);
        busy_d    = (state_d != IDLE);
    end

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Self-checking bench for clk_gen_ctrl: directed vector table plus
// multi-cycle waveform sequences against hand-derived period lengths.
module tb_clk_gen_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CFG_WR;
    logic [7:0]  CFG_HIGH, CFG_LOW;
    logic        START, STOP;
    logic [15:0] BURST_LEN;
    logic        CLK_OUT, RISE, FALL, BUSY, DONE;

    int checks = 0;
    int errors = 0;

    clk_gen_ctrl #(
        .CNT_WIDTH    (8),
        .BURST_WIDTH  (16),
        .DEFAULT_HIGH (10),
        .DEFAULT_LOW  (10)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CFG_WR    (CFG_WR),
        .CFG_HIGH  (CFG_HIGH),
        .CFG_LOW   (CFG_LOW),
        .START     (START),
        .STOP      (STOP),
        .BURST_LEN (BURST_LEN),
        .CLK_OUT   (CLK_OUT),
        .RISE      (RISE),
        .FALL      (FALL),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    // One table row: inputs applied for one edge, outputs {clk,rise,fall,busy,done} after it.
    typedef struct {
        logic        cfg_wr;
        logic [7:0]  h;
        logic [7:0]  l;
        logic        start;
        logic        stop;
        logic [15:0] blen;
        logic [4:0]  exp;
    } vec_t;

    vec_t vecs [32];
    int   nv;

    // Expected period lengths for run_wave
    int exp_h [4];
    int exp_l [4];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [4:0] exp);
        check({tag, " CLK_OUT"}, CLK_OUT, exp[4]);
        check({tag, " RISE"},    RISE,    exp[3]);
        check({tag, " FALL"},    FALL,    exp[2]);
        check({tag, " BUSY"},    BUSY,    exp[1]);
        check({tag, " DONE"},    DONE,    exp[0]);
    endtask

    function automatic vec_t mk(input logic cw, input logic [7:0] h, input logic [7:0] l,
                                input logic st, input logic sp, input logic [15:0] bl,
                                input logic [4:0] e);
        vec_t v;
        v.cfg_wr = cw; v.h = h; v.l = l; v.start = st; v.stop = sp; v.blen = bl; v.exp = e;
        return v;
    endfunction

    task automatic add(input vec_t v);
        vecs[nv] = v;
        nv++;
    endtask

    // Start a run and compare every cycle with the waveform implied by exp_h/exp_l.
    // Optional single-cycle injections (cycle 0 = none): config write, START while busy, STOP.
    task automatic run_wave(input string name, input logic [15:0] blen, input logic stop0,
                            input int np, input int cfg_at, input logic [7:0] ch,
                            input logic [7:0] cl, input int xstart_at, input int stop_at);
        int total;
        int base;
        int o;
        int hp;
        logic in_run;
        logic [4:0] e;
        total = 0;
        for (int p = 0; p < np; p++) total += exp_h[p] + exp_l[p];
        START = 1'b1; STOP = stop0; BURST_LEN = blen;
        step();
        START = 1'b0; STOP = 1'b0;
        for (int c = 1; c <= total + 2; c++) begin
            base = 0; in_run = 1'b0; o = 0; hp = 0;
            for (int p = 0; p < np; p++) begin
                if (!in_run && c > base && c <= base + exp_h[p] + exp_l[p]) begin
                    in_run = 1'b1;
                    o  = c - base - 1;
                    hp = exp_h[p];
                end
                base += exp_h[p] + exp_l[p];
            end
            if (in_run) e = {(o < hp), (o == 0), (o == hp), 1'b1, 1'b0};
            else        e = {4'b0000, (c == total + 1)};
            check_outs($sformatf("%s c%0d", name, c), e);
            if (c == cfg_at)    begin CFG_WR = 1'b1; CFG_HIGH = ch; CFG_LOW = cl; end
            if (c == xstart_at) begin START = 1'b1; BURST_LEN = 16'd7; end
            if (c == stop_at)   STOP = 1'b1;
            step();
            CFG_WR = 1'b0; START = 1'b0; STOP = 1'b0;
        end
    endtask

    initial begin
        RESET = 1'b1; CFG_WR = 1'b0; CFG_HIGH = '0; CFG_LOW = '0;
        START = 1'b0; STOP = 1'b0; BURST_LEN = '0;

        // Vector table: zero clamp, forwarding, START with DONE, STOP in IDLE
        nv = 0;
        add(mk(1, 8'd0, 8'd0, 0, 0, 16'd0, 5'b00000));
        add(mk(0, 8'd0, 8'd0, 1, 0, 16'd4, 5'b11010));
        add(mk(0, 8'd0, 8'd0, 0, 0, 16'd0, 5'b00110));
        add(mk(0, 8'd0, 8'd0, 0, 0, 16'd0, 5'b11010));
        add(mk(0, 8'd0, 8'd0, 0, 0, 16'd0, 5'b00110));
        add(mk(0, 8'd0, 8'd0, 0, 0, 16'd0, 5'b11010));
        add(mk(0, 8'd0, 8'd0, 0, 0, 16'd0, 5'b00110));
        add(mk(0, 8'd0, 8'd0, 0, 0, 16'd0, 5'b11010));
        add(mk(0, 8'd0, 8'd0, 0, 0, 16'd0, 5'b00110));
        add(mk(0, 8'd0, 8'd0, 0, 0, 16'd0, 5'b00001));
        add(mk(0, 8'd0, 8'd0, 0, 0, 16'd0, 5'b00000));
        add(mk(1, 8'd2, 8'd2, 1, 0, 16'd1, 5'b11010));
        add(mk(0, 8'd0, 8'd0, 0, 0, 16'd0, 5'b10010));
        add(mk(0, 8'd0, 8'd0, 0, 0, 16'd0, 5'b00110));
        add(mk(0, 8'd0, 8'd0, 0, 0, 16'd0, 5'b00010));
        add(mk(0, 8'd0, 8'd0, 0, 0, 16'd0, 5'b00001));
        add(mk(0, 8'd0, 8'd0, 1, 0, 16'd1, 5'b11010));
        add(mk(0, 8'd0, 8'd0, 0, 0, 16'd0, 5'b10010));
        add(mk(0, 8'd0, 8'd0, 0, 0, 16'd0, 5'b00110));
        add(mk(0, 8'd0, 8'd0, 0, 0, 16'd0, 5'b00010));
        add(mk(0, 8'd0, 8'd0, 0, 0, 16'd0, 5'b00001));
        add(mk(0, 8'd0, 8'd0, 0, 1, 16'd0, 5'b00000));
        add(mk(0, 8'd0, 8'd0, 0, 0, 16'd0, 5'b00000));

        // Reset state
        step();
        step();
        check_outs("reset", 5'b00000);
        RESET = 1'b0;
        step();
        check_outs("post_reset", 5'b00000);

        // Defaults, burst of two
        exp_h[0] = 10; exp_l[0] = 10; exp_h[1] = 10; exp_l[1] = 10;
        run_wave("defaults", 16'd2, 1'b0, 2, 0, 8'd0, 8'd0, 0, 0);

        // START and STOP together in IDLE: one period despite BURST_LEN=3
        exp_h[0] = 10; exp_l[0] = 10;
        run_wave("start_stop", 16'd3, 1'b1, 1, 0, 8'd0, 8'd0, 0, 0);

        // START while busy is ignored, including its BURST_LEN
        exp_h[0] = 10; exp_l[0] = 10; exp_h[1] = 10; exp_l[1] = 10;
        run_wave("start_busy", 16'd2, 1'b0, 2, 0, 8'd0, 8'd0, 15, 0);

        // Reprogram during period 1 of a continuous run, STOP in period 3
        exp_h[0] = 10; exp_l[0] = 10; exp_h[1] = 3; exp_l[1] = 5; exp_h[2] = 3; exp_l[2] = 5;
        run_wave("reprogram", 16'd0, 1'b0, 3, 5, 8'd3, 8'd5, 0, 30);

        // Async reset in the fifth HIGH cycle
        CFG_WR = 1'b1; CFG_HIGH = 8'd20; CFG_LOW = 8'd20;
        step();
        CFG_WR = 1'b0;
        START = 1'b1; BURST_LEN = 16'd0;
        step();
        START = 1'b0;
        repeat (4) step();
        check_outs("pre_reset_c5", 5'b10010);
        #2 RESET = 1'b1;
        #1;
        check_outs("async_reset", 5'b00000);
        step();
        check_outs("in_reset", 5'b00000);
        RESET = 1'b0;
        step();
        check_outs("after_reset", 5'b00000);

        // Shadow registers back at defaults after reset
        exp_h[0] = 10; exp_l[0] = 10;
        run_wave("reset_defaults", 16'd1, 1'b0, 1, 0, 8'd0, 8'd0, 0, 0);

        // Table-driven vectors
        for (int i = 0; i < nv; i++) begin
            CFG_WR = vecs[i].cfg_wr; CFG_HIGH = vecs[i].h; CFG_LOW = vecs[i].l;
            START = vecs[i].start; STOP = vecs[i].stop; BURST_LEN = vecs[i].blen;
            step();
            CFG_WR = 1'b0; START = 1'b0; STOP = 1'b0;
            check_outs($sformatf("vec%0d", i), vecs[i].exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
